// File: rtl/sha256_block_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sha256_block_sched
// Buffers 16-word message blocks, sequences the SHA-256 round core (init + 68
// EN cycles per block) and presents the latched digest on a valid/ready port.
// Rev    : 1.0
// ============================================================================
module sha256_block_sched #(
    parameter int BLK_CYCLES = 68,
    parameter int LOAD_WORDS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         core_init,
    output logic         core_en,
    output logic [31:0]  core_idata,
    input  logic         core_busy,
    input  logic [255:0] core_hash,
    output logic         d_valid,
    input  logic         d_ready,
    output logic [255:0] d_digest,
    output logic         err
);

    localparam int c_wptr_w = $clog2(LOAD_WORDS);
    localparam int c_rcnt_w = $clog2(BLK_CYCLES);
    localparam logic [c_wptr_w-1:0] c_wlast     = c_wptr_w'(LOAD_WORDS - 1);
    localparam logic [c_rcnt_w-1:0] c_rload     = c_rcnt_w'(LOAD_WORDS - 1);
    localparam logic [c_rcnt_w-1:0] c_rbusy_end = c_rcnt_w'(BLK_CYCLES - 2);
    localparam logic [c_rcnt_w-1:0] c_rlast     = c_rcnt_w'(BLK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_INIT  = 3'd2,
        S_RUN   = 3'd3,
        S_LATCH = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [c_wptr_w-1:0]   wcnt_q, wcnt_d;
    logic [c_rcnt_w-1:0]   rcnt_q, rcnt_d;
    logic                  full_q, full_d;
    logic                  last_blk_q, last_blk_d;
    logic                  cur_last_q, cur_last_d;
    logic                  first_q, first_d;
    logic                  live_q, live_d;
    logic                  d_valid_q, d_valid_d;
    logic [255:0]          d_digest_q, d_digest_d;
    logic                  err_q, err_d;
    logic [31:0]           buf_q [LOAD_WORDS];
    logic [31:0]           buf_d [LOAD_WORDS];

    logic                  w_accept;
    logic                  w_wrap;
    logic                  w_run;
    logic                  w_busy_win;

    assign w_run      = (state_q == S_RUN);
    assign w_busy_win = w_run && (rcnt_q >= c_rload) && (rcnt_q <= c_rbusy_end);

    // live_q keeps s_ready low while reset is asserted and for the first cycle after
    assign s_ready  = live_q && !full_q && (!w_run || (int'(rcnt_q) >= LOAD_WORDS));
    assign w_accept = s_valid && s_ready;
    assign w_wrap   = w_accept && (wcnt_q == c_wlast);

    assign core_en    = w_run;
    assign core_init  = (state_q == S_INIT);
    assign core_idata = (w_run && (int'(rcnt_q) < LOAD_WORDS)) ? buf_q[rcnt_q[c_wptr_w-1:0]] : 32'd0;
    assign d_valid    = d_valid_q;
    assign d_digest   = d_digest_q;
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        full_d     = full_q;
        last_blk_d = last_blk_q;
        cur_last_d = cur_last_q;
        first_d    = first_q;
        live_d     = 1'b1;
        d_valid_d  = d_valid_q;
        d_digest_d = d_digest_q;
        buf_d      = buf_q;

        if (w_accept) begin
            buf_d[wcnt_q] = s_data;
            wcnt_d        = w_wrap ? '0 : wcnt_q + 1'b1;
        end
        if (w_wrap) begin
            full_d     = 1'b1;
            last_blk_d = s_last;
        end

        // Transitions look at full_d so a block completing this edge starts without a bubble
        case (state_q)
            S_IDLE, S_FILL: begin
                if (full_d) begin
                    if (first_q) begin
                        state_d = S_INIT;
                    end else begin
                        state_d    = S_RUN;
                        cur_last_d = last_blk_d;
                    end
                end
            end
            S_INIT: begin
                state_d    = S_RUN;
                cur_last_d = last_blk_d;
            end
            S_RUN: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == c_rload) begin
                    full_d = 1'b0;
                end
                if (rcnt_q == c_rlast) begin
                    rcnt_d  = '0;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cur_last_q) begin
                    d_digest_d = core_hash;
                    d_valid_d  = 1'b1;
                    first_d    = 1'b1;
                    state_d    = S_OUT;
                end else begin
                    first_d = 1'b0;
                    if (full_d) begin
                        state_d    = S_RUN;
                        cur_last_d = last_blk_d;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_OUT: begin
                if (d_ready) begin
                    d_valid_d = 1'b0;
                    state_d   = full_d ? S_INIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = err_q || (w_busy_win && !core_busy) || (!w_run && core_busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            full_q     <= 1'b0;
            last_blk_q <= 1'b0;
            cur_last_q <= 1'b0;
            first_q    <= 1'b1;
            live_q     <= 1'b0;
            d_valid_q  <= 1'b0;
            d_digest_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            full_q     <= full_d;
            last_blk_q <= last_blk_d;
            cur_last_q <= cur_last_d;
            first_q    <= first_d;
            live_q     <= live_d;
            d_valid_q  <= d_valid_d;
            d_digest_q <= d_digest_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_sha256_block_sched
// Drives sha256_block_sched against a behavioural SHA-256 core model.
// Rev    : 1.0
// ============================================================================
module tb_sha256_block_sched;

    localparam logic [255:0] c_iv  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_two = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid, s_ready, s_last;
    logic [31:0]  s_data;
    logic         core_init, core_en, core_busy;
    logic [31:0]  core_idata;
    logic [255:0] core_hash;
    logic         d_valid, d_ready, err;
    logic [255:0] d_digest;
    logic         kill;

    always #5 clk = ~clk;

    sha256_block_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .core_init  (core_init),
        .core_en    (core_en),
        .core_idata (core_idata),
        .core_busy  (core_busy),
        .core_hash  (core_hash),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_digest   (d_digest),
        .err        (err)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full SHA-256 compression of one block; word i of the block sits at [32*i +: 32]
    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + c_k[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Core model: takes idata on EN rounds 0..15, busy on rounds 15..66, hash updated at round 67
    int unsigned  cnt_m;
    logic [511:0] w_m;
    logic [255:0] h_m;
    assign core_hash = h_m;
    assign core_busy = (cnt_m >= 15) && (cnt_m <= 66) && !kill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m <= 0;
            h_m   <= '0;
        end else if (core_init) begin
            cnt_m <= 0;
            h_m   <= c_iv;
        end else if (core_en) begin
            if (cnt_m < 16) w_m[32*cnt_m +: 32] <= core_idata;
            if (cnt_m == 67) begin
                h_m   <= sha_compress(h_m, w_m);
                cnt_m <= 0;
            end else begin
                cnt_m <= cnt_m + 1;
            end
        end
    end

    // Protocol monitors sampled on the falling edge
    int unsigned  cyc = 0;
    int unsigned  init_cnt = 0, both_cnt = 0, run = 0, runs = 0, bad_run = 0;
    int unsigned  gap = 0, last_gap = 0, sready_bad = 0, unstable = 0, dv_drop = 0, rise_cyc = 0;
    int unsigned  got_n = 0;
    logic [255:0] got [16];
    logic         dv_prev = 1'b0, rdy_prev = 1'b0;
    logic [255:0] dig_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            run     <= 0;
            gap     <= 0;
            dv_prev <= 1'b0;
        end else begin
            if (core_init) init_cnt <= init_cnt + 1;
            if (core_init && core_en) both_cnt <= both_cnt + 1;
            if (core_en) begin
                run <= run + 1;
                gap <= 0;
                if (run == 0) last_gap <= gap;
                if (run < 16 && s_ready) sready_bad <= sready_bad + 1;
            end else begin
                gap <= gap + 1;
                run <= 0;
                if (run != 0) begin
                    runs <= runs + 1;
                    if (run != 68) bad_run <= bad_run + 1;
                end
            end
            if (d_valid && !dv_prev) rise_cyc <= cyc;
            if (dv_prev && d_valid && d_digest !== dig_prev) unstable <= unstable + 1;
            if (dv_prev && !d_valid && !rdy_prev) dv_drop <= dv_drop + 1;
            if (d_valid && d_ready && got_n < 16) begin
                got[got_n] <= d_digest;
                got_n      <= got_n + 1;
            end
            dv_prev  <= d_valid;
            dig_prev <= d_digest;
            rdy_prev <= d_ready;
        end
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int unsigned acc15 = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input bit rnd);
        int n = 0;
        while (rnd && $urandom_range(1, 0) == 1) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 3000) begin
                $error("FAIL send_timeout: observed s_ready=0 expected 1");
                $fatal(1, "input stalled");
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [511:0] blk, input logic last, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            send_word(blk[32*i +: 32], (i == 15) ? last : (rnd ? 1'($urandom_range(1, 0)) : 1'b0), rnd);
        end
        acc15 = cyc;
    endtask

    task automatic wait_dig(input int unsigned target, input string tag);
        int n = 0;
        while (got_n < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 256'(got_n >= target), 256'(1));
    endtask

    task automatic wait_run(input int unsigned pos, input string tag);
        int n = 0;
        while (run != pos && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 256'(run), 256'(pos));
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc_blk, two_b0, two_b1, exp_h;
        logic [511:0] rb [3];
        logic [7:0]   ch;
        int unsigned  i0, r0, rd;

        abc_blk = '0;
        abc_blk[31:0] = 32'h61626380;
        abc_blk[32*15 +: 32] = 32'h00000018;
        two_b0 = '0;
        for (int i = 0; i < 14; i++) begin
            ch = 8'h61 + 8'(i);
            two_b0[32*i +: 32] = {ch, ch + 8'd1, ch + 8'd2, ch + 8'd3};
        end
        two_b0[32*14 +: 32] = 32'h80000000;
        two_b1 = '0;
        two_b1[32*15 +: 32] = 32'h000001c0;
        rd = 0;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; d_ready = 1'b1; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 256'(s_ready), 256'(0));
        chk("rst_d_valid", 256'(d_valid), 256'(0));
        chk("rst_core_en", 256'(core_en), 256'(0));
        chk("rst_err", 256'(err), 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-block "abc"
        i0 = init_cnt; r0 = runs;
        send_block(abc_blk, 1'b1, 1'b0);
        chk("full_blocks_input", 256'(s_ready), 256'(0));
        wait_dig(rd + 1, "t1_wait");
        chk("t1_digest", got[rd], c_abc); rd++;
        chk("t1_latency", 256'(rise_cyc - acc15), 256'(70));
        chk("t1_inits", 256'(init_cnt - i0), 256'(1));
        chk("t1_runs", 256'(runs - r0), 256'(1));

        // Two-block message streamed without gaps
        i0 = init_cnt; r0 = runs;
        send_block(two_b0, 1'b0, 1'b0);
        send_block(two_b1, 1'b1, 1'b0);
        wait_dig(rd + 1, "t2_wait");
        chk("t2_digest", got[rd], c_two); rd++;
        chk("t2_inits", 256'(init_cnt - i0), 256'(1));
        chk("t2_runs", 256'(runs - r0), 256'(2));
        chk("t2_gap", 256'(last_gap), 256'(1));

        // Random s_valid gaps and a stalled digest consumer
        r0 = runs;
        d_ready = 1'b0;
        send_block(abc_blk, 1'b1, 1'b1);
        for (int n = 0; n < 3000 && !d_valid; n++) begin
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("t3_dvalid_held", 256'(d_valid), 256'(1));
        chk("t3_no_handshake", 256'(got_n), 256'(rd));
        d_ready = 1'b1;
        wait_dig(rd + 1, "t3_wait");
        chk("t3_digest", got[rd], c_abc); rd++;
        chk("t3_runs", 256'(runs - r0), 256'(1));

        // Back-to-back messages, second streamed during the first's RUN
        i0 = init_cnt;
        send_block(abc_blk, 1'b1, 1'b0);
        send_block(abc_blk, 1'b1, 1'b0);
        chk("t4_full_blocks", 256'(s_ready), 256'(0));
        wait_dig(rd + 2, "t4_wait");
        chk("t4_digest_a", got[rd], c_abc); rd++;
        chk("t4_digest_b", got[rd], c_abc); rd++;
        chk("t4_inits", 256'(init_cnt - i0), 256'(2));

        // Random 3-block message, random gaps and junk s_last on non-final words
        i0 = init_cnt;
        exp_h = {256'd0, c_iv};
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) rb[b][32*i +: 32] = $urandom;
            exp_h[255:0] = sha_compress(exp_h[255:0], rb[b]);
        end
        for (int b = 0; b < 3; b++) send_block(rb[b], b == 2, 1'b1);
        wait_dig(rd + 1, "t5_wait");
        chk("t5_digest", got[rd], exp_h[255:0]); rd++;
        chk("t5_inits", 256'(init_cnt - i0), 256'(1));

        // Reset in the middle of a block
        send_block(abc_blk, 1'b1, 1'b0);
        wait_run(30, "t6_reach_rcnt30");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_core_en", 256'(core_en), 256'(0));
        chk("t6_rst_core_init", 256'(core_init), 256'(0));
        chk("t6_rst_idata", 256'(core_idata), 256'(0));
        chk("t6_rst_s_ready", 256'(s_ready), 256'(0));
        chk("t6_rst_d_valid", 256'(d_valid), 256'(0));
        chk("t6_rst_digest", d_digest, 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        i0 = init_cnt;
        send_block(abc_blk, 1'b1, 1'b0);
        wait_dig(rd + 1, "t6_wait");
        chk("t6_digest", got[rd], c_abc); rd++;
        chk("t6_inits", 256'(init_cnt - i0), 256'(1));
        chk("t6_err", 256'(err), 256'(0));

        // core_busy dropped mid-block
        send_block(abc_blk, 1'b1, 1'b0);
        wait_run(40, "t7_reach_rcnt40");
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("t7_err_set", 256'(err), 256'(1));
        wait_dig(rd + 1, "t7_wait");
        rd++;
        repeat (5) @(posedge clk);
        #1;
        chk("t7_err_sticky", 256'(err), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("t7_err_cleared", 256'(err), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("init_en_overlap", 256'(both_cnt), 256'(0));
        chk("en_run_length", 256'(bad_run), 256'(0));
        chk("s_ready_early", 256'(sready_bad), 256'(0));
        chk("digest_stable", 256'(unstable), 256'(0));
        chk("dvalid_dropped", 256'(dv_drop), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
